// File: rtl/debug_frame_ctrl_if.sv
// rtl/debug_frame_ctrl_if.sv - UART FIFO and debug RAM port bundle for the debug frame controller
interface debug_frame_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_pop;
    logic              tx_ready;
    logic [7:0]        tx_data;
    logic              tx_wr;
    logic [31:0]       mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_sel;

    modport master (
        input  rx_data, rx_valid, tx_ready, mem_rdata,
        output rx_pop, tx_data, tx_wr, mem_addr, mem_sel
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, mem_rdata,
        input  rx_pop, tx_data, tx_wr, mem_addr, mem_sel
    );
endinterface

// File: rtl/debug_frame_ctrl.sv
// rtl/debug_frame_ctrl.sv - UART-driven run/step/breakpoint control with framed pipeline snapshot dump
module debug_frame_ctrl #(
    parameter int NUM_BYTES = 95,
    parameter int MEM_WORDS = 5,
    parameter int PC_W      = 8,
    parameter int ADDR_W    = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   end_of_program,
    input  logic [PC_W-1:0]        pc,
    input  logic [NUM_BYTES*8-1:0] snap_bus,
    debug_frame_ctrl_if.master     bus,
    output logic                   pipe_enable,
    output logic                   pipe_reset,
    output logic [2:0]             state_o
);
    localparam int TOTAL = NUM_BYTES + 4*MEM_WORDS + 2;
    localparam int IDX_W = $clog2(TOTAL);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(TOTAL - 1);
    localparam logic [IDX_W-1:0]  SNAP_END  = IDX_W'(NUM_BYTES);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_WORDS - 1);
    localparam logic [7:0] CMD_C = 8'h63, CMD_S = 8'h73, CMD_B = 8'h62, CMD_N = 8'h6e, CMD_X = 8'h78;

    typedef enum logic [2:0] {IDLE, CONT, STEP, BRK_ARG, LATCH, SEND, DONE} state_t;

    state_t                 state, stateNext, ret, retNext, brkRet, brkRetNext;
    logic [PC_W-1:0]        bpPc;
    logic                   bpEn, setBp, clrBp, stopNow;
    logic [NUM_BYTES*8-1:0] snapReg;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W+2:0]       snapOff;
    logic [1:0]             byteSel;
    logic [ADDR_W-1:0]      memAddr;
    logic [23:0]            memLow;
    logic                   bubble, txWr, inRam;
    logic [7:0]             txData;

    assign stopNow = end_of_program || (bpEn && pc == bpPc);
    assign txWr    = (state == SEND) && !bubble && bus.tx_ready;
    assign inRam   = (idx > SNAP_END) && (idx != LAST_IDX);
    assign snapOff = {idx - IDX_W'(1), 3'b000};

    always_comb begin
        stateNext   = state;
        retNext     = ret;
        brkRetNext  = brkRet;
        bus.rx_pop  = 1'b0;
        pipe_enable = 1'b0;
        setBp       = 1'b0;
        clrBp       = 1'b0;
        case (state)
            IDLE, STEP: if (bus.rx_valid) begin
                bus.rx_pop = 1'b1;
                case (bus.rx_data)
                    CMD_C: stateNext = CONT;
                    CMD_S: stateNext = STEP;
                    CMD_B: begin brkRetNext = state; stateNext = BRK_ARG; end
                    CMD_X: clrBp = 1'b1;
                    CMD_N: if (state == STEP) begin
                        pipe_enable = 1'b1;
                        retNext     = end_of_program ? IDLE : STEP;
                        stateNext   = LATCH;
                    end
                    default: ;
                endcase
            end
            BRK_ARG: if (bus.rx_valid) begin
                bus.rx_pop = 1'b1;
                setBp      = 1'b1;
                stateNext  = brkRet;
            end
            // Stop must gate the enable in the very cycle it is seen
            CONT: if (stopNow) begin
                retNext   = end_of_program ? IDLE : STEP;
                stateNext = LATCH;
            end else begin
                pipe_enable = 1'b1;
            end
            LATCH:   stateNext = SEND;
            SEND:    if (txWr && idx == LAST_IDX) stateNext = DONE;
            DONE:    stateNext = ret;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        txData = 8'h00;
        if (idx == '0)
            txData = 8'hA5;
        else if (idx <= SNAP_END)
            txData = snapReg[snapOff +: 8];
        else if (idx == LAST_IDX)
            txData = 8'h5A;
        else
            case (byteSel)
                2'd0:    txData = bus.mem_rdata[31:24];
                2'd1:    txData = memLow[23:16];
                2'd2:    txData = memLow[15:8];
                default: txData = memLow[7:0];
            endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            ret     <= IDLE;
            brkRet  <= IDLE;
            bpEn    <= 1'b0;
            bpPc    <= '0;
            snapReg <= '0;
            idx     <= '0;
            byteSel <= '0;
            memAddr <= '0;
            memLow  <= '0;
            bubble  <= 1'b0;
        end else begin
            state  <= stateNext;
            ret    <= retNext;
            brkRet <= brkRetNext;
            if (setBp) begin
                bpPc <= bus.rx_data[PC_W-1:0];
                bpEn <= 1'b1;
            end
            if (clrBp) bpEn <= 1'b0;
            if (bubble) bubble <= 1'b0;
            if (state == LATCH) begin
                snapReg <= snap_bus;
                memAddr <= '0;
                idx     <= '0;
                byteSel <= '0;
                bubble  <= 1'b0;
            end
            if (txWr) begin
                idx <= idx + IDX_W'(1);
                if (inRam) begin
                    if (byteSel == 2'd0) memLow <= bus.mem_rdata[23:0];
                    byteSel <= byteSel + 2'd1;
                    // Next word's read data lands one cycle after the address moves
                    if (byteSel == 2'd3 && memAddr != LAST_WORD) begin
                        memAddr <= memAddr + ADDR_W'(1);
                        bubble  <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.tx_wr    = txWr;
    assign bus.tx_data  = (state == SEND) ? txData : 8'h00;
    assign bus.mem_addr = memAddr;
    assign bus.mem_sel  = (state == LATCH) || (state == SEND);
    assign pipe_reset   = (state == IDLE);
    assign state_o      = state;
endmodule

// File: tb/tb_debug_frame_ctrl.sv
// tb/tb_debug_frame_ctrl.sv - scoreboard bench for debug_frame_ctrl
module tb_debug_frame_ctrl;
    localparam int NB = 95, MW = 5;
    localparam logic [2:0] S_IDLE = 3'd0, S_CONT = 3'd1, S_STEP = 3'd2, S_SEND = 3'd5;

    logic          clock = 0, reset = 1, end_of_program = 0;
    logic [7:0]    pc = 0;
    logic [NB*8-1:0] snap_bus = '0;
    logic          pipe_enable, pipe_reset;
    logic [2:0]    state_o;

    debug_frame_ctrl_if #(.ADDR_W(8)) bus();

    debug_frame_ctrl dut (
        .clock(clock), .reset(reset), .end_of_program(end_of_program), .pc(pc),
        .snap_bus(snap_bus), .bus(bus), .pipe_enable(pipe_enable),
        .pipe_reset(pipe_reset), .state_o(state_o)
    );

    always #5 clock = ~clock;

    int nTests = 0, nFail = 0;
    int sbQ[$];
    logic [7:0] rxQ[$];
    logic [31:0] ram [0:255];
    int frameBytes = 0, enCount = 0, enBase;
    bit popSeen = 0, enSeen = 0, stallMode = 0;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void refreshRx();
        bus.rx_valid = (rxQ.size() > 0);
        bus.rx_data  = (rxQ.size() > 0) ? rxQ[0] : 8'h00;
    endfunction

    task automatic sendBytes(input logic [7:0] b0, input logic [7:0] b1, input int n);
        rxQ.push_back(b0);
        if (n > 1) rxQ.push_back(b1);
        refreshRx();
    endtask

    task automatic pushFrame();
        sbQ.push_back(8'hA5);
        for (int k = 0; k < NB; k++) sbQ.push_back(int'(snap_bus[8*k +: 8]));
        for (int w = 0; w < MW; w++)
            for (int b = 3; b >= 0; b--) sbQ.push_back(int'(ram[w][8*b +: 8]));
        sbQ.push_back(8'h5A);
        frameBytes = 0;
    endtask

    task automatic randSnap();
        for (int k = 0; k < NB; k++) snap_bus[8*k +: 8] = 8'($urandom);
    endtask

    task automatic waitFor(input logic [2:0] st, input int budget, input string tag);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (state_o == st && sbQ.size() == 0) begin ok = 1; break; end
        end
        checkEq(tag, ok, 1);
    endtask

    task automatic waitState(input logic [2:0] st, input int budget, input string tag);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (state_o == st) begin ok = 1; break; end
        end
        checkEq(tag, ok, 1);
    endtask

    // Monitor: scoreboard compare, enable counting
    always @(negedge clock) begin
        popSeen = bus.rx_pop;
        enSeen  = pipe_enable;
        if (pipe_enable) enCount++;
        if (bus.tx_wr) begin
            int exp;
            exp = (sbQ.size() > 0) ? sbQ.pop_front() : 32'h100;
            checkEq("tx_byte", {56'd0, bus.tx_data}, 64'(exp));
            checkEq("tx_wr_ready", bus.tx_ready, 1);
            frameBytes++;
        end
    end

    // RX FIFO, datapath PC, registered RAM read, TX stall
    always @(posedge clock) begin
        #1;
        if (popSeen && rxQ.size() > 0) void'(rxQ.pop_front());
        refreshRx();
        if (enSeen) pc = pc + 8'd1;
        if (stallMode) bus.tx_ready = ~bus.tx_ready;
    end

    always @(posedge clock) bus.mem_rdata <= ram[bus.mem_addr];

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = $urandom;
        bus.tx_ready = 1;
        refreshRx();
        randSnap();
        repeat (3) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        checkEq("rst_state", state_o, S_IDLE);
        checkEq("rst_pipe_reset", pipe_reset, 1);
        checkEq("rst_pipe_enable", pipe_enable, 0);
        checkEq("rst_tx_wr", bus.tx_wr, 0);
        checkEq("rst_mem_sel", bus.mem_sel, 0);
        checkEq("rst_rx_pop", bus.rx_pop, 0);

        // single step
        enBase = enCount;
        pushFrame();
        sendBytes(8'h73, 8'h6e, 2);
        waitFor(S_STEP, 1000, "step_done");
        checkEq("step_len", frameBytes, 117);
        checkEq("step_en_pulses", enCount - enBase, 1);

        // stalled TX
        pushFrame();
        stallMode = 1;
        sendBytes(8'h6e, 8'h00, 1);
        waitFor(S_STEP, 2000, "stall_done");
        stallMode = 0;
        bus.tx_ready = 1;
        checkEq("stall_len", frameBytes, 117);

        // breakpoint run
        pc = 8'h0C;
        enBase = enCount;
        pushFrame();
        sendBytes(8'h62, 8'h10, 2);
        sendBytes(8'h63, 8'h00, 1);
        waitState(S_CONT, 50, "bp_enter_cont");
        begin
            bit hit = 0;
            for (int i = 0; i < 50; i++) begin
                if (state_o == S_CONT && pc == 8'h10) begin
                    checkEq("bp_stop_en", pipe_enable, 0);
                    hit = 1;
                    break;
                end
                @(negedge clock);
            end
            checkEq("bp_hit", hit, 1);
        end
        waitFor(S_STEP, 1000, "bp_done");
        checkEq("bp_len", frameBytes, 117);
        checkEq("bp_en_pulses", enCount - enBase, 4);
        checkEq("bp_pc_hold", pc, 8'h10);

        // breakpoint and end_of_program together
        end_of_program = 1;
        enBase = enCount;
        pushFrame();
        sendBytes(8'h63, 8'h00, 1);
        waitFor(S_IDLE, 1000, "both_done");
        repeat (20) @(negedge clock);
        checkEq("both_len", frameBytes, 117);
        checkEq("both_state", state_o, S_IDLE);
        checkEq("both_pipe_reset", pipe_reset, 1);
        checkEq("both_en", enCount - enBase, 0);
        end_of_program = 0;

        // snapshot changes during SEND must not leak into the frame
        sendBytes(8'h73, 8'h6e, 2);
        pushFrame();
        waitState(S_SEND, 50, "latch_send");
        randSnap();
        waitFor(S_STEP, 1000, "latch_done");
        checkEq("latch_len", frameBytes, 117);

        // reset mid-frame
        pushFrame();
        sendBytes(8'h6e, 8'h00, 1);
        begin
            bit hit = 0;
            for (int i = 0; i < 500; i++) begin
                @(negedge clock);
                if (frameBytes >= 40) begin hit = 1; break; end
            end
            checkEq("abort_reach40", hit, 1);
        end
        reset = 1;
        @(posedge clock);
        @(negedge clock);
        checkEq("abort_tx_wr", bus.tx_wr, 0);
        checkEq("abort_state", state_o, S_IDLE);
        checkEq("abort_mem_sel", bus.mem_sel, 0);
        sbQ.delete();
        #1 reset = 0;
        repeat (5) @(negedge clock);
        checkEq("abort_quiet", frameBytes < 43, 1);

        // breakpoint cleared by reset: pc at old bp must not stop CONT
        pc = 8'h10;
        sendBytes(8'h63, 8'h00, 1);
        waitState(S_CONT, 50, "bpclr_cont");
        checkEq("bpclr_en", pipe_enable, 1);
        pushFrame();
        end_of_program = 1;
        waitFor(S_IDLE, 1000, "eop_done");
        checkEq("eop_len", frameBytes, 117);
        end_of_program = 0;

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
